// File: rtl/instr_trace_monitor_if.sv
// Trace input and debug read-back bundle for instr_trace_monitor.
// master: retire source / debug reader; slave: the monitor.
interface instr_trace_monitor_if #(
  parameter int AW = 4
);
  logic          in_valid;
  logic [31:0]   in_instr;
  logic [31:0]   in_pc;
  logic          rd_req;
  logic [AW-1:0] rd_idx;
  logic          rd_valid;
  logic          rd_err;
  logic [31:0]   rd_instr;
  logic [31:0]   rd_pc;
  logic [4:0]    rd_class;

  modport master (
    output in_valid, in_instr, in_pc,
    output rd_req, rd_idx,
    input  rd_valid, rd_err,
    input  rd_instr, rd_pc, rd_class
  );

  modport slave (
    input  in_valid, in_instr, in_pc,
    input  rd_req, rd_idx,
    output rd_valid, rd_err,
    output rd_instr, rd_pc, rd_class
  );
endinterface

// File: rtl/instr_trace_monitor.sv
// Retired MIPS instruction classifier: saturating per-class and total
// counters plus a circular trace buffer with a 1-cycle read port.
// Ports: clk, rst_n (async low); bus (trace in + read port, slave);
// clr (sync clear); cls_sel/cls_count; total_count; unknown_count;
// fill (valid entries); halted (capture stopped after SYSCALL).
module instr_trace_monitor #(
  parameter int DEPTH           = 16,
  parameter int CNT_W           = 16,
  parameter bit STOP_ON_SYSCALL = 1'b1,
  localparam int AW             = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  instr_trace_monitor_if.slave bus,
  input  logic                 clr,
  input  logic [4:0]           cls_sel,
  output logic [CNT_W-1:0]     cls_count,
  output logic [CNT_W-1:0]     total_count,
  output logic [CNT_W-1:0]     unknown_count,
  output logic [AW:0]          fill,
  output logic                 halted
);
  localparam int          NCLS  = 25;
  localparam logic [AW:0] FULL  = (AW+1)'(DEPTH);
  localparam logic [4:0]  C_SYS = 5'd13;

  typedef enum logic {RUN, HALT} state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [4:0]  cls;
  } ent_t;

  state_t          state_q;
  logic            halted_q;
  ent_t            mem_q [DEPTH];
  logic [AW-1:0]   wptr_q;
  logic [AW:0]     fill_q;
  logic [CNT_W-1:0] cnt_q [NCLS];
  logic [CNT_W-1:0] tot_q;
  logic            rd_valid_q;
  logic            rd_err_q;
  ent_t            rd_q;

  logic [5:0]      op;
  logic [5:0]      fn;
  logic [4:0]      cls_d;
  logic            acc;
  logic [AW-1:0]   slot;
  logic            rd_oob;
  ent_t            wr_ent;

  assign op = bus.in_instr[31:26];
  assign fn = bus.in_instr[5:0];

  always_comb begin
    cls_d = 5'd0;
    if (op == 6'd0) begin
      case (fn)
        6'd0:    cls_d = 5'd1;
        6'd3:    cls_d = 5'd2;
        6'd2:    cls_d = 5'd3;
        6'd32:   cls_d = 5'd4;
        6'd33:   cls_d = 5'd5;
        6'd34:   cls_d = 5'd6;
        6'd36:   cls_d = 5'd7;
        6'd37:   cls_d = 5'd8;
        6'd39:   cls_d = 5'd9;
        6'd42:   cls_d = 5'd10;
        6'd43:   cls_d = 5'd11;
        6'd8:    cls_d = 5'd12;
        6'd12:   cls_d = 5'd13;
        default: cls_d = 5'd0;
      endcase
    end else begin
      case (op)
        6'd2:    cls_d = 5'd14;
        6'd3:    cls_d = 5'd15;
        6'd4:    cls_d = 5'd16;
        6'd5:    cls_d = 5'd17;
        6'd8:    cls_d = 5'd18;
        6'd9:    cls_d = 5'd19;
        6'd12:   cls_d = 5'd20;
        6'd10:   cls_d = 5'd21;
        6'd13:   cls_d = 5'd22;
        6'd35:   cls_d = 5'd23;
        6'd43:   cls_d = 5'd24;
        default: cls_d = 5'd0;
      endcase
    end
  end

  // clr wins over a same-cycle accept
  assign acc    = bus.in_valid && (state_q == RUN) && !clr;
  assign wr_ent = {bus.in_instr, bus.in_pc, cls_d};

  // Oldest entry sits fill slots behind wptr; when full the
  // low AW bits of fill are zero so the oldest is wptr itself.
  assign slot   = wptr_q - fill_q[AW-1:0] + bus.rd_idx;
  assign rd_oob = {1'b0, bus.rd_idx} >= fill_q;

  // Trace RAM carries no reset; unused slots are never read.
  always_ff @(posedge clk) begin
    if (acc) mem_q[wptr_q] <= wr_ent;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      halted_q <= 1'b0;
      wptr_q   <= '0;
      fill_q   <= '0;
      tot_q    <= '0;
      for (int i = 0; i < NCLS; i++) cnt_q[i] <= '0;
    end else if (clr) begin
      state_q  <= RUN;
      halted_q <= 1'b0;
      wptr_q   <= '0;
      fill_q   <= '0;
      tot_q    <= '0;
      for (int i = 0; i < NCLS; i++) cnt_q[i] <= '0;
    end else if (acc) begin
      wptr_q <= wptr_q + AW'(1);
      if (fill_q != FULL)
        fill_q <= fill_q + (AW+1)'(1);
      if (tot_q != '1)
        tot_q <= tot_q + CNT_W'(1);
      if (cnt_q[cls_d] != '1)
        cnt_q[cls_d] <= cnt_q[cls_d] + CNT_W'(1);
      if (STOP_ON_SYSCALL && cls_d == C_SYS) begin
        state_q  <= HALT;
        halted_q <= 1'b1;
      end
    end
  end

  // Reads see pre-edge RAM, so a same-cycle write stays invisible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
      rd_q       <= '0;
    end else if (bus.rd_req) begin
      rd_valid_q <= 1'b1;
      rd_err_q   <= rd_oob;
      rd_q       <= rd_oob ? '0 : mem_q[slot];
    end else begin
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
    end
  end

  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_err   = rd_err_q;
  assign bus.rd_instr = rd_q.instr;
  assign bus.rd_pc    = rd_q.pc;
  assign bus.rd_class = rd_q.cls;

  assign cls_count     = (cls_sel < 5'(NCLS)) ? cnt_q[cls_sel] : '0;
  assign total_count   = tot_q;
  assign unknown_count = cnt_q[0];
  assign fill          = fill_q;
  assign halted        = halted_q;
endmodule

// File: doc/instr_trace_monitor.md
Name: instr_trace_monitor

Overview:
Parametrised, synthesizable successor to the simulation-only instruction display monitor. Classifies each retired MIPS instruction into a 5-bit class code and keeps saturating per-class and total counters. Records instruction and PC in a circular trace buffer that debug logic can read back. Sits beside the ID stage, sampling the decoded instruction word; it has no effect on the pipeline.

Parameters:
DEPTH, 16, trace buffer entries; power of two, minimum 2; AW = log2(DEPTH)
CNT_W, 16, width of every counter
STOP_ON_SYSCALL, 1, 1 = capture halts after a SYSCALL is recorded; 0 = free-running

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  in_instr/in_pc hold a retiring instruction this cycle
in_instr  in  32  instruction word
in_pc  in  32  instruction PC
clr  in  1  synchronous clear of counters, buffer and halt state
rd_req  in  1  trace read request
rd_idx  in  AW  entry index; 0 = oldest valid entry
rd_valid  out  1  read response strobe
rd_err  out  1  with rd_valid: rd_idx >= fill at request time
rd_instr  out  32  entry instruction
rd_pc  out  32  entry PC
rd_class  out  5  entry class code
cls_sel  in  5  class selected for cls_count
cls_count  out  CNT_W  counter of class cls_sel (combinational from registers)
total_count  out  CNT_W  accepted instructions
unknown_count  out  CNT_W  accepted instructions of class 0
fill  out  AW+1  valid buffer entries, 0..DEPTH
halted  out  1  state == HALT

Behaviour:
- Reset: asynchronous, active-low. While rst_n is low, every counter, fill, the write pointer, rd_valid, rd_err, rd_instr, rd_pc, rd_class and halted are 0, and state = RUN. Buffer RAM contents are don't-care.
- Classification, Op = in_instr[31:26], Func = in_instr[5:0]:
  - Op=0, Func to class: 0→1 SLL, 3→2 SRA, 2→3 SRL, 32→4 ADD, 33→5 ADDU, 34→6 SUB, 36→7 AND, 37→8 OR, 39→9 NOR, 42→10 SLT, 43→11 SLTU, 8→12 JR, 12→13 SYSCALL.
  - Op≠0, Op to class: 2→14 J, 3→15 JAL, 4→16 BEQ, 5→17 BNE, 8→18 ADDI, 9→19 ADDIU, 12→20 ANDI, 10→21 SLTI, 13→22 ORI, 35→23 LW, 43→24 SW.
  - Any other encoding → class 0 (UNKNOWN). Codes 25..31 are never produced; cls_count reads 0 for them.
- FSM has two states:
  - RUN: a cycle with in_valid=1 is accepted.
  - HALT: in_valid is ignored; nothing is written or counted.
  - RUN→HALT on accepting class 13 when STOP_ON_SYSCALL=1. The SYSCALL itself is recorded and counted.
  - HALT→RUN only on clr. Reset also returns to RUN.
- Accept, effective at the next edge:
  - buffer[wptr] <= {in_instr, in_pc, class}; wptr <= wptr+1 modulo DEPTH.
  - fill increments and saturates at DEPTH. When full, the oldest entry is overwritten.
  - total_count, the selected class counter and (if class 0) unknown_count each increment. Each counter saturates at 2^CNT_W-1 independently.
- Read path, latency 1:
  - rd_req in cycle N → rd_valid=1 in cycle N+1 for exactly one cycle.
  - Physical slot = (wptr - fill + rd_idx) mod DEPTH, using wptr and fill as they stand in cycle N.
  - A write accepted in cycle N is not visible to that read.
  - If rd_idx >= fill in cycle N: rd_err=1 and rd_instr/rd_pc/rd_class=0.
  - Back-to-back reads are allowed every cycle.
  - Outputs hold their value while rd_valid=0; rd_err=0 whenever rd_valid=0.
- clr, synchronous: zeroes all counters, fill and wptr, and sets state = RUN.
  - clr has priority over a same-cycle accept; that instruction is dropped.
  - A read requested in the same cycle as clr still completes against pre-clear state.
- Reset asserted mid-read: the response is lost; rd_valid=0.

Test Plan:
- After reset, send ADD 0x012A4020 @PC 0x0 and LW 0x8D090004 @PC 0x4 → total=2, cls_count[4]=1, cls_count[23]=1, fill=2. Read idx1 → rd_valid next cycle, rd_instr=0x8D090004, rd_pc=0x4, rd_class=23.
- DEPTH=16: send 20 ORI instructions with PC=4*i → fill=16, total=20. Read idx0 → rd_pc=0x10 (oldest surviving). Read idx15 → rd_pc=0x4C.
- STOP_ON_SYSCALL=1: send ADDI, SYSCALL 0x0000000C, then 3 more valid instructions → halted=1, total=2, cls_count[13]=1. Pulse clr → halted=0, all counters 0, fill=0.
- Send opcode 0x3F word 0xFC000000 and Op=0/Func=1 word 0x00000001 → class 0 both, unknown_count=2. cls_sel=27 → cls_count=0.
- CNT_W=4: send 17 SW → cls_count[24]=15 and total_count=15, both saturated. Read idx=fill while fill<DEPTH → rd_err=1, rd_class=0. Assert rd_req and in_valid in the same cycle → read returns pre-write data.
